// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target controller.
// Optional: I2C_SLAVE_STRETCH_EN adds the STRETCH state.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_WAIT_STOP
`ifdef I2C_SLAVE_STRETCH_EN
    ,
    S_STRETCH
`endif
  } i2c_slv_state_e;

endpackage

// File: rtl/i2c_slave_ctrl_if.sv
// Bus pins plus rx/tx byte streams of the I2C target.
// slave: controller side; master: bus model / user side.
interface i2c_slave_ctrl_if
  import i2c_pkg::*;
();

  logic                  scl_in;
  logic                  sda_in;
  logic                  scl_out;
  logic                  scl_oen;
  logic                  sda_out;
  logic                  sda_oen;
  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_first;
  logic [I2C_BYTE_W-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ack;
  logic                  busy;
  logic                  rd_nwr;
  logic                  nack_rcvd;

  modport slave (
    input  scl_in, sda_in,
    input  tx_data, tx_valid,
    output scl_out, scl_oen,
    output sda_out, sda_oen,
    output rx_data, rx_valid, rx_first,
    output tx_ack, busy, rd_nwr,
    output nack_rcvd
  );

  modport master (
    output scl_in, sda_in,
    output tx_data, tx_valid,
    input  scl_out, scl_oen,
    input  sda_out, sda_oen,
    input  rx_data, rx_valid, rx_first,
    input  tx_ack, busy, rd_nwr,
    input  nack_rcvd
  );

endinterface

// File: rtl/i2c_line_filter.sv
// 2-flop sync + FILTER_LEN stability filter + edge pulses.
// Ports: i_line in; o_level, o_rise, o_fall out (registered).
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] r_sync;
  logic [3:0] r_cnt;
  logic       r_level;
  logic       r_rise;
  logic       r_fall;

  // Level moves only after FILTER_LEN equal samples that
  // differ from it; the edge pulse lands with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == 4'(FILTER_LEN - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_rise  <= r_sync[1];
        r_fall  <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target: START/STOP decode, 7-bit match, write/read bytes.
// Ports: clk, rst_n, bus (i2c_slave_ctrl_if.slave). Macro: I2C_SLAVE_STRETCH_EN.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50,
  parameter int                    FILTER_LEN = 3
) (
  input logic             clk,
  input logic             rst_n,
  i2c_slave_ctrl_if.slave bus
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_line  (bus.scl_in),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_line  (bus.sda_in),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  i2c_slv_state_e        r_state;
  logic [I2C_BYTE_W-1:0] r_shift;
  logic [I2C_BYTE_W-1:0] r_tx;
  logic [3:0]            r_bitcnt;
  logic                  r_first;
  logic                  r_ack_ok;
  logic                  r_sda_oen;
  logic [I2C_BYTE_W-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_rx_first;
  logic                  r_tx_ack;
  logic                  r_busy;
  logic                  r_rd_nwr;
  logic                  r_nack;
`ifdef I2C_SLAVE_STRETCH_EN
  logic                  r_scl_oen;
  logic [1:0]            r_hold;
`endif

  logic w_start, w_stop, w_match, w_rd_enter;

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;
  // General call (0x00) never matches.
  assign w_match = (r_shift[7:1] == SLAVE_ADDR) &&
                   (r_shift[7:1] != '0);
  // Falling edges that start a read byte.
  assign w_rd_enter = w_scl_fall &&
    ((r_state == S_ADDR_ACK && r_rd_nwr) ||
     (r_state == S_RD_ACK && r_ack_ok));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_tx       <= '0;
      r_bitcnt   <= '0;
      r_first    <= 1'b0;
      r_ack_ok   <= 1'b0;
      r_sda_oen  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_first <= 1'b0;
      r_tx_ack   <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_nwr   <= 1'b0;
      r_nack     <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      r_scl_oen  <= 1'b0;
      r_hold     <= '0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_ack   <= 1'b0;
      r_nack     <= 1'b0;
      if (w_stop) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_sda_oen <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
        r_scl_oen <= 1'b0;
        r_hold    <= '0;
`endif
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_busy    <= 1'b1;
        r_bitcnt  <= '0;
        r_ack_ok  <= 1'b0;
        r_sda_oen <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
        r_scl_oen <= 1'b0;
        r_hold    <= '0;
`endif
      end else if (w_rd_enter) begin
        r_bitcnt <= '0;
`ifdef I2C_SLAVE_STRETCH_EN
        if (bus.tx_valid) begin
          r_tx      <= bus.tx_data;
          r_tx_ack  <= 1'b1;
          r_sda_oen <= ~bus.tx_data[7];
          r_state   <= S_RD_DATA;
        end else begin
          r_sda_oen <= 1'b0;
          r_scl_oen <= 1'b1;
          r_hold    <= '0;
          r_state   <= S_STRETCH;
        end
`else
        // No data ready: the released line reads as 0xFF.
        r_tx      <= bus.tx_valid ? bus.tx_data : 8'hFF;
        r_tx_ack  <= bus.tx_valid;
        r_sda_oen <= bus.tx_valid & ~bus.tx_data[7];
        r_state   <= S_RD_DATA;
`endif
      end else begin
        unique case (r_state)
          S_IDLE: ;
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift  <= {r_shift[6:0], w_sda};
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              if (w_match) begin
                r_rd_nwr  <= r_shift[0];
                r_sda_oen <= 1'b1;
                r_first   <= 1'b1;
                r_state   <= S_ADDR_ACK;
              end else begin
                r_state <= S_WAIT_STOP;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oen <= 1'b0;
              r_bitcnt  <= '0;
              r_state   <= S_WR_DATA;
            end
          end
          S_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift  <= {r_shift[6:0], w_sda};
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
              r_rx_first <= r_first;
              r_first    <= 1'b0;
              r_sda_oen  <= 1'b1;
              r_state    <= S_WR_ACK;
            end
          end
          S_WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oen <= 1'b0;
              r_bitcnt  <= '0;
              r_state   <= S_WR_DATA;
            end
          end
          S_RD_DATA: begin
            if (w_scl_fall) begin
              if (r_bitcnt == 4'd7) begin
                r_sda_oen <= 1'b0;
                r_ack_ok  <= 1'b0;
                r_state   <= S_RD_ACK;
              end else begin
                r_sda_oen <= ~r_tx[6];
                r_tx      <= {r_tx[6:0], 1'b0};
                r_bitcnt  <= r_bitcnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise) begin
              if (w_sda) begin
                r_nack  <= 1'b1;
                r_state <= S_WAIT_STOP;
              end else begin
                r_ack_ok <= 1'b1;
              end
            end
          end
          S_WAIT_STOP: ;
`ifdef I2C_SLAVE_STRETCH_EN
          S_STRETCH: begin
            // MSB is on SDA for two cycles before SCL is let go.
            if (r_hold == 2'd0) begin
              if (bus.tx_valid) begin
                r_tx      <= bus.tx_data;
                r_tx_ack  <= 1'b1;
                r_sda_oen <= ~bus.tx_data[7];
                r_hold    <= 2'd1;
              end
            end else if (r_hold == 2'd1) begin
              r_hold <= 2'd2;
            end else begin
              r_hold    <= '0;
              r_scl_oen <= 1'b0;
              r_state   <= S_RD_DATA;
            end
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.scl_out   = 1'b0;
  assign bus.sda_out   = 1'b0;
  assign bus.sda_oen   = r_sda_oen;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.rx_first  = r_rx_first;
  assign bus.tx_ack    = r_tx_ack;
  assign bus.busy      = r_busy;
  assign bus.rd_nwr    = r_rd_nwr;
  assign bus.nack_rcvd = r_nack;
`ifdef I2C_SLAVE_STRETCH_EN
  assign bus.scl_oen   = r_scl_oen;
`else
  assign bus.scl_oen   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl with rx/rd scoreboards.
// Master bus model drives open-drain SCL/SDA with pull-ups.
module tb_i2c_slave_ctrl;
  import i2c_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_slave_ctrl_if bus ();

  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  assign bus.scl_in = m_scl & ~bus.scl_oen;
  assign bus.sda_in = m_sda & ~bus.sda_oen;

  i2c_slave_ctrl #(
    .SLAVE_ADDR (7'h50),
    .FILTER_LEN (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_rd[$];
  logic [8:0] exp_rx[$];
  logic [8:0] rx_obs[$];
  int n_rxv = 0;
  int n_txack = 0;
  int n_nack = 0;
  int n_sda_drv = 0;

  // tx source and output monitor
  always @(negedge clk) begin
    if (bus.tx_ack && tx_q.size() != 0)
      void'(tx_q.pop_front());
    bus.tx_data <= (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    if (bus.rx_valid)
      rx_obs.push_back({bus.rx_first, bus.rx_data});
    if (bus.rx_valid)  n_rxv <= n_rxv + 1;
    if (bus.tx_ack)    n_txack <= n_txack + 1;
    if (bus.nack_rcvd) n_nack <= n_nack + 1;
    if (bus.sda_oen)   n_sda_drv <= n_sda_drv + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_scl_high();
    int t = 0;
    while (bus.scl_in !== 1'b1 && t < 5000) begin
      cyc(1);
      t++;
    end
    if (t >= 5000)
      chk("scl_release_bound", 32'(bus.scl_in), 32'd1);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    cyc(10);
    m_sda = b;
    cyc(10);
    m_scl = 1'b1;
    wait_scl_high();
    cyc(10);
    s = bus.sda_in;
    cyc(10);
    m_scl = 1'b0;
  endtask

  task automatic start_c();
    cyc(10);
    m_sda = 1'b0;
    cyc(20);
    m_scl = 1'b0;
  endtask

  task automatic rstart_c();
    cyc(10);
    m_sda = 1'b1;
    cyc(10);
    m_scl = 1'b1;
    wait_scl_high();
    cyc(10);
    m_sda = 1'b0;
    cyc(10);
    m_scl = 1'b0;
  endtask

  task automatic stop_c();
    cyc(10);
    m_sda = 1'b0;
    cyc(10);
    m_scl = 1'b1;
    wait_scl_high();
    cyc(10);
    m_sda = 1'b1;
    cyc(20);
  endtask

  task automatic write_byte(input logic [7:0] d,
                            output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack,
                           output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clk_bit(~mack, s);
  endtask

  task automatic chk_rx(input string tag);
    logic [8:0] o;
    logic [8:0] e;
    chk({tag, "_avail"},
        32'(rx_obs.size() != 0 && exp_rx.size() != 0),
        32'd1);
    if (rx_obs.size() != 0 && exp_rx.size() != 0) begin
      o = rx_obs.pop_front();
      e = exp_rx.pop_front();
      chk(tag, 32'(o), 32'(e));
    end
  endtask

  task automatic chk_rd(input string tag,
                        input logic [7:0] d);
    chk({tag, "_avail"}, 32'(exp_rd.size() != 0), 32'd1);
    if (exp_rd.size() != 0)
      chk(tag, 32'(d), 32'(exp_rd.pop_front()));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    logic s;
    logic [7:0] d;
    int b_rx, b_tx, b_nk, b_sda, held;
    logic [7:0] exp_t6;
    int exp_held, exp_t6ack;

    bus.tx_valid = 1'b1;
    cyc(5);
    chk("reset_outputs",
        32'({bus.sda_oen, bus.scl_oen, bus.sda_out,
             bus.scl_out, bus.rx_valid, bus.rx_first,
             bus.tx_ack, bus.busy, bus.rd_nwr,
             bus.nack_rcvd, bus.rx_data}), 32'd0);
    chk("reset_state", 32'(dut.r_state), 32'(S_IDLE));
    rst_n = 1'b1;
    cyc(10);

    // write 0xA5, 0x3C
    b_rx = n_rxv;
    start_c();
    chk("t1_busy", 32'(bus.busy), 32'd1);
    write_byte(8'hA0, ack);
    chk("t1_addr_ack", 32'(ack), 32'd1);
    exp_rx.push_back({1'b1, 8'hA5});
    write_byte(8'hA5, ack);
    chk("t1_d0_ack", 32'(ack), 32'd1);
    exp_rx.push_back({1'b0, 8'h3C});
    write_byte(8'h3C, ack);
    chk("t1_d1_ack", 32'(ack), 32'd1);
    stop_c();
    chk("t1_busy_end", 32'(bus.busy), 32'd0);
    chk_rx("t1_rx0");
    chk_rx("t1_rx1");
    chk("t1_rx_pulses", 32'(n_rxv - b_rx), 32'd2);

    // wrong address
    b_rx = n_rxv;
    b_sda = n_sda_drv;
    start_c();
    write_byte(8'hA2, ack);
    chk("t2_addr_nack", 32'(ack), 32'd0);
    chk("t2_state", 32'(dut.r_state), 32'(S_WAIT_STOP));
    write_byte(8'h77, ack);
    chk("t2_data_nack", 32'(ack), 32'd0);
    chk("t2_state2", 32'(dut.r_state), 32'(S_WAIT_STOP));
    stop_c();
    chk("t2_idle", 32'(dut.r_state), 32'(S_IDLE));
    chk("t2_sda_drv", 32'(n_sda_drv - b_sda), 32'd0);
    chk("t2_rx_pulses", 32'(n_rxv - b_rx), 32'd0);

    // read 0x96, 0x0F
    b_tx = n_txack;
    b_nk = n_nack;
    tx_q.push_back(8'h96);
    tx_q.push_back(8'h0F);
    exp_rd.push_back(8'h96);
    exp_rd.push_back(8'h0F);
    start_c();
    write_byte(8'hA1, ack);
    chk("t3_addr_ack", 32'(ack), 32'd1);
    chk("t3_rd_nwr", 32'(bus.rd_nwr), 32'd1);
    read_byte(1'b1, d);
    chk_rd("t3_rd0", d);
    read_byte(1'b0, d);
    chk_rd("t3_rd1", d);
    stop_c();
    chk("t3_tx_acks", 32'(n_txack - b_tx), 32'd2);
    chk("t3_nacks", 32'(n_nack - b_nk), 32'd1);

    // write then repeated-start read
    b_rx = n_rxv;
    start_c();
    write_byte(8'hA0, ack);
    chk("t4_addr_ack", 32'(ack), 32'd1);
    chk("t4_rd_nwr0", 32'(bus.rd_nwr), 32'd0);
    exp_rx.push_back({1'b1, 8'h11});
    write_byte(8'h11, ack);
    chk("t4_d_ack", 32'(ack), 32'd1);
    rstart_c();
    chk("t4_busy_rs", 32'(bus.busy), 32'd1);
    tx_q.push_back(8'h22);
    exp_rd.push_back(8'h22);
    write_byte(8'hA1, ack);
    chk("t4_raddr_ack", 32'(ack), 32'd1);
    chk("t4_rd_nwr1", 32'(bus.rd_nwr), 32'd1);
    read_byte(1'b0, d);
    chk_rd("t4_rd", d);
    stop_c();
    chk_rx("t4_rx");
    chk("t4_rx_pulses", 32'(n_rxv - b_rx), 32'd1);

    // partial byte then STOP; reset mid-read
    b_rx = n_rxv;
    start_c();
    write_byte(8'hA0, ack);
    chk("t5_addr_ack", 32'(ack), 32'd1);
    clk_bit(1'b1, s);
    clk_bit(1'b0, s);
    clk_bit(1'b1, s);
    clk_bit(1'b0, s);
    stop_c();
    chk("t5_rx_pulses", 32'(n_rxv - b_rx), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_idle", 32'(dut.r_state), 32'(S_IDLE));
    tx_q.push_back(8'hC3);
    start_c();
    write_byte(8'hA1, ack);
    chk("t5_raddr_ack", 32'(ack), 32'd1);
    clk_bit(1'b1, s);
    clk_bit(1'b1, s);
    cyc(10);
    chk("t5_drive_low", 32'(bus.sda_oen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_oen",
        32'({bus.sda_oen, bus.scl_oen}), 32'd0);
    chk("t5_rst_rx_data", 32'(bus.rx_data), 32'd0);
    cyc(3);
    m_scl = 1'b1;
    m_sda = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    chk("t5_rst_idle", 32'(dut.r_state), 32'(S_IDLE));

    // tx_valid held low for 50 cycles
`ifdef I2C_SLAVE_STRETCH_EN
    exp_t6 = 8'h5A;
    exp_held = 50;
    exp_t6ack = 1;
`else
    exp_t6 = 8'hFF;
    exp_held = 0;
    exp_t6ack = 0;
`endif
    b_tx = n_txack;
    bus.tx_valid = 1'b0;
    tx_q.push_back(8'h5A);
    start_c();
    write_byte(8'hA1, ack);
    chk("t6_addr_ack", 32'(ack), 32'd1);
    cyc(8);
    held = 0;
    repeat (50) begin
      cyc(1);
      if (bus.scl_oen === 1'b1) held++;
    end
    chk("t6_scl_held", 32'(held), 32'(exp_held));
    bus.tx_valid = 1'b1;
    read_byte(1'b0, d);
    chk("t6_byte", 32'(d), 32'(exp_t6));
    stop_c();
    chk("t6_tx_acks", 32'(n_txack - b_tx), 32'(exp_t6ack));
    chk("t6_scl_free", 32'(bus.scl_oen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
